// File: rtl/regfile_sb_pkg.sv
// Shared types and default geometry for the register file, so decode and
// writeback agree on word width, register count and the link register.
package regfile_sb_pkg;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_LINK_REG = DEF_NUM_REGS - 1;
   localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

   typedef logic [DEF_DATA_W-1:0] word_t;
   typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_sb_fwd.sv
// Next-value mux for one register read: forwards same-cycle write data with
// port 2 priority, and forces register 0 to zero when it is hardwired.
module regfile_sb_fwd #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 0
) (
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] cur,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              wr_en2,
   input  logic [ADDR_W-1:0] wr_addr2,
   input  logic [DATA_W-1:0] wr_data2,
   output logic [DATA_W-1:0] nxt
);
   always_comb begin
      nxt = cur;
      if (wr_en1 && (wr_addr1 == addr)) nxt = wr_data1;
      if (wr_en2 && (wr_addr2 == addr)) nxt = wr_data2;
      if ((ZERO_REG != 0) && (addr == '0)) nxt = '0;
   end
endmodule

// File: rtl/regfile_sb.sv
// Register file with two write ports, registered reads with optional
// write-through bypass, a per-register busy scoreboard and a link tap.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS,
   localparam int ADDR_W  = $clog2(NUM_REGS),
   parameter int LINK_REG = NUM_REGS - 1,
   parameter int ZERO_REG = 0,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] rd_data1,
   output logic [DATA_W-1:0] rd_data2,
   output logic              busy1,
   output logic              busy2,
   input  logic              wr_en1,
   input  logic [ADDR_W-1:0] wr_addr1,
   input  logic [DATA_W-1:0] wr_data1,
   input  logic              wr_en2,
   input  logic [ADDR_W-1:0] wr_addr2,
   input  logic [DATA_W-1:0] wr_data2,
   input  logic              rsv_en,
   input  logic [ADDR_W-1:0] rsv_addr,
   output logic [DATA_W-1:0] link_data
);
   localparam logic [ADDR_W-1:0] LINK_ADDR = ADDR_W'(LINK_REG);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [DATA_W-1:0]   fwd1, fwd2, fwd_link;
   logic                wr_ok1, wr_ok2, rsv_ok;

   // A hardwired register 0 swallows writes and reservations alike.
   assign wr_ok1 = wr_en1 && !((ZERO_REG != 0) && (wr_addr1 == '0));
   assign wr_ok2 = wr_en2 && !((ZERO_REG != 0) && (wr_addr2 == '0));
   assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

   // Reservation is applied last: a new producer overrides a retiring one.
   always_comb begin
      busy_nxt = busy;
      if (wr_ok1) busy_nxt[wr_addr1] = 1'b0;
      if (wr_ok2) busy_nxt[wr_addr2] = 1'b0;
      if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
   end

   regfile_sb_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd1 (
      .addr(rd_addr1), .cur(regs[rd_addr1]),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
      .nxt(fwd1)
   );

   regfile_sb_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd2 (
      .addr(rd_addr2), .cur(regs[rd_addr2]),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
      .nxt(fwd2)
   );

   regfile_sb_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_fwd_link (
      .addr(LINK_ADDR), .cur(regs[LINK_ADDR]),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
      .nxt(fwd_link)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         busy      <= '0;
         rd_data1  <= '0;
         rd_data2  <= '0;
         busy1     <= 1'b0;
         busy2     <= 1'b0;
         link_data <= '0;
      end else begin
         if (wr_ok1) regs[wr_addr1] <= wr_data1;
         if (wr_ok2) regs[wr_addr2] <= wr_data2;
         busy <= busy_nxt;
         if (BYPASS != 0) begin
            rd_data1  <= fwd1;
            rd_data2  <= fwd2;
            link_data <= fwd_link;
            busy1     <= busy_nxt[rd_addr1];
            busy2     <= busy_nxt[rd_addr2];
         end else begin
            rd_data1  <= regs[rd_addr1];
            rd_data2  <= regs[rd_addr2];
            link_data <= regs[LINK_ADDR];
            busy1     <= busy[rd_addr1];
            busy2     <= busy[rd_addr2];
         end
      end
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: directed scenarios plus randomized traffic, all
// checked against an array-based model of the register file and scoreboard.
module tb_regfile_sb;
   import regfile_sb_pkg::*;

   localparam int NR = DEF_NUM_REGS;
   localparam int ZR = 1;
   localparam int BP = 1;

   logic      clk = 1'b0;
   logic      rst = 1'b0;
   reg_addr_t rd_addr1 = '0, rd_addr2 = '0;
   word_t     rd_data1, rd_data2, link_data;
   logic      busy1, busy2;
   logic      wr_en1 = 1'b0, wr_en2 = 1'b0, rsv_en = 1'b0;
   reg_addr_t wr_addr1 = '0, wr_addr2 = '0, rsv_addr = '0;
   word_t     wr_data1 = '0, wr_data2 = '0;

   int n_cmp  = 0;
   int n_fail = 0;

   word_t m_regs [NR];
   logic  m_busy [NR];
   word_t exp_rd1, exp_rd2, exp_link;
   logic  exp_b1, exp_b2;

   regfile_sb #(.ZERO_REG(ZR), .BYPASS(BP)) dut (
      .clk(clk), .rst(rst),
      .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(rd_data1), .rd_data2(rd_data2),
      .busy1(busy1), .busy2(busy2),
      .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
      .wr_en2(wr_en2), .wr_addr2(wr_addr2), .wr_data2(wr_data2),
      .rsv_en(rsv_en), .rsv_addr(rsv_addr),
      .link_data(link_data)
   );

   always #5 clk = ~clk;

   // Drives one cycle of inputs, predicts the registered outputs from the
   // architectural rules, then advances past the edge.
   task automatic step(input logic rs, input reg_addr_t a1, input reg_addr_t a2,
                       input logic e1, input reg_addr_t w1a, input word_t w1d,
                       input logic e2, input reg_addr_t w2a, input word_t w2d,
                       input logic re, input reg_addr_t ra);
      word_t nr [NR];
      logic  nb [NR];
      rst = rs; rd_addr1 = a1; rd_addr2 = a2;
      wr_en1 = e1; wr_addr1 = w1a; wr_data1 = w1d;
      wr_en2 = e2; wr_addr2 = w2a; wr_data2 = w2d;
      rsv_en = re; rsv_addr = ra;
      if (!rs) begin
         for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
         end
         exp_rd1 = '0; exp_rd2 = '0; exp_link = '0; exp_b1 = 1'b0; exp_b2 = 1'b0;
      end else begin
         nr = m_regs;
         nb = m_busy;
         if (e1 && !(ZR != 0 && w1a == 0)) begin nr[w1a] = w1d; nb[w1a] = 1'b0; end
         if (e2 && !(ZR != 0 && w2a == 0)) begin nr[w2a] = w2d; nb[w2a] = 1'b0; end
         if (re && !(ZR != 0 && ra == 0)) nb[ra] = 1'b1;
         exp_rd1  = (BP != 0) ? nr[a1] : m_regs[a1];
         exp_rd2  = (BP != 0) ? nr[a2] : m_regs[a2];
         exp_link = (BP != 0) ? nr[NR-1] : m_regs[NR-1];
         exp_b1   = (BP != 0) ? nb[a1] : m_busy[a1];
         exp_b2   = (BP != 0) ? nb[a2] : m_busy[a2];
         m_regs = nr;
         m_busy = nb;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_read(input reg_addr_t a1, input reg_addr_t a2);
      step(1'b1, a1, a2, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
   endtask

   task automatic test_reset;
      step(1'b0, 4'd0, 4'd0, 1'b1, 4'd3, 16'h1111, 1'b1, 4'd15, 16'h2222, 1'b1, 4'd3);
      step(1'b0, 4'd3, 4'd15, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      n_cmp++; if (rd_data1 !== 16'h0000) begin n_fail++; $display("FAIL rst_rd1 got %h want 0000", rd_data1); end
      n_cmp++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL rst_busy2 got %b want 0", busy2); end
      n_cmp++; if (link_data !== 16'h0000) begin n_fail++; $display("FAIL rst_link got %h want 0000", link_data); end
      idle_read(4'd3, 4'd15);
      n_cmp++; if (rd_data1 !== 16'h0000) begin n_fail++; $display("FAIL read_r3 got %h want 0000", rd_data1); end
      n_cmp++; if (rd_data2 !== 16'h0000) begin n_fail++; $display("FAIL read_r15 got %h want 0000", rd_data2); end
      n_cmp++; if (link_data !== 16'h0000) begin n_fail++; $display("FAIL link_after_rst got %h want 0000", link_data); end
      n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL busy_r3 got %b want 0", busy1); end
   endtask

   task automatic test_dual_write;
      step(1'b1, 4'd0, 4'd0, 1'b1, 4'd4, 16'h1234, 1'b1, 4'd5, 16'hABCD, 1'b0, '0);
      idle_read(4'd4, 4'd5);
      n_cmp++; if (rd_data1 !== 16'h1234) begin n_fail++; $display("FAIL dual_r4 got %h want 1234", rd_data1); end
      n_cmp++; if (rd_data2 !== 16'hABCD) begin n_fail++; $display("FAIL dual_r5 got %h want abcd", rd_data2); end
      step(1'b1, 4'd0, 4'd0, 1'b1, 4'd6, 16'h1111, 1'b1, 4'd6, 16'h2222, 1'b0, '0);
      idle_read(4'd6, 4'd6);
      n_cmp++; if (rd_data1 !== 16'h2222) begin n_fail++; $display("FAIL collide_r6 got %h want 2222", rd_data1); end
      n_cmp++; if (rd_data2 !== 16'h2222) begin n_fail++; $display("FAIL collide_r6_p2 got %h want 2222", rd_data2); end
   endtask

   task automatic test_bypass;
      word_t want;
      want = (BP != 0) ? 16'h00F0 : 16'h0000;
      step(1'b1, 4'd2, 4'd2, 1'b1, 4'd2, 16'h00F0, 1'b0, '0, '0, 1'b0, '0);
      n_cmp++; if (rd_data1 !== want) begin n_fail++; $display("FAIL bypass_r2 got %h want %h", rd_data1, want); end
      step(1'b1, 4'd9, 4'd9, 1'b1, 4'd9, 16'h0001, 1'b1, 4'd9, 16'h0002, 1'b0, '0);
      want = (BP != 0) ? 16'h0002 : 16'h0000;
      n_cmp++; if (rd_data2 !== want) begin n_fail++; $display("FAIL bypass_prio got %h want %h", rd_data2, want); end
   endtask

   task automatic test_scoreboard;
      step(1'b1, 4'd0, 4'd0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 4'd7);
      idle_read(4'd7, 4'd0);
      n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rsv_r7 got %b want 1", busy1); end
      step(1'b1, 4'd0, 4'd0, 1'b1, 4'd7, 16'h0F0F, 1'b0, '0, '0, 1'b0, '0);
      idle_read(4'd7, 4'd0);
      n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL wb_clear_r7 got %b want 0", busy1); end
      n_cmp++; if (rd_data1 !== 16'h0F0F) begin n_fail++; $display("FAIL wb_data_r7 got %h want 0f0f", rd_data1); end
      step(1'b1, 4'd0, 4'd0, 1'b0, '0, '0, 1'b1, 4'd7, 16'h7777, 1'b1, 4'd7);
      idle_read(4'd7, 4'd7);
      n_cmp++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL rsv_wins_r7 got %b want 1", busy1); end
      n_cmp++; if (rd_data2 !== 16'h7777) begin n_fail++; $display("FAIL rsv_wr_data_r7 got %h want 7777", rd_data2); end
   endtask

   task automatic test_link_zero;
      step(1'b1, 4'd0, 4'd0, 1'b0, '0, '0, 1'b1, 4'd15, 16'hBEEF, 1'b0, '0);
      idle_read(4'd0, 4'd0);
      n_cmp++; if (link_data !== 16'hBEEF) begin n_fail++; $display("FAIL link_r15 got %h want beef", link_data); end
      step(1'b1, 4'd0, 4'd0, 1'b1, 4'd0, 16'hFFFF, 1'b0, '0, '0, 1'b1, 4'd0);
      idle_read(4'd0, 4'd0);
      n_cmp++; if (rd_data1 !== 16'h0000) begin n_fail++; $display("FAIL zero_data got %h want 0000", rd_data1); end
      n_cmp++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL zero_busy got %b want 0", busy2); end
   endtask

   task automatic test_reset_mid;
      step(1'b1, 4'd0, 4'd0, 1'b1, 4'd8, 16'h5555, 1'b0, '0, '0, 1'b1, 4'd3);
      step(1'b0, 4'd3, 4'd8, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
      idle_read(4'd3, 4'd8);
      n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy_r3 got %b want 0", busy1); end
      n_cmp++; if (rd_data2 !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_r8 got %h want 0000", rd_data2); end
      n_cmp++; if (link_data !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_link got %h want 0000", link_data); end
   endtask

   task automatic test_random;
      logic rs;
      for (int c = 0; c < 400; c++) begin
         rs = ($urandom_range(0, 59) != 0);
         step(rs, 4'($urandom_range(0, NR-1)), 4'($urandom_range(0, NR-1)),
              1'($urandom), 4'($urandom_range(0, NR-1)), 16'($urandom),
              1'($urandom), 4'($urandom_range(0, NR-1)), 16'($urandom),
              1'($urandom), 4'($urandom_range(0, NR-1)));
         n_cmp++; if (rd_data1 !== exp_rd1) begin n_fail++; $display("FAIL rand_rd1 cyc %0d got %h want %h", c, rd_data1, exp_rd1); end
         n_cmp++; if (rd_data2 !== exp_rd2) begin n_fail++; $display("FAIL rand_rd2 cyc %0d got %h want %h", c, rd_data2, exp_rd2); end
         n_cmp++; if (busy1 !== exp_b1) begin n_fail++; $display("FAIL rand_busy1 cyc %0d got %b want %b", c, busy1, exp_b1); end
         n_cmp++; if (busy2 !== exp_b2) begin n_fail++; $display("FAIL rand_busy2 cyc %0d got %b want %b", c, busy2, exp_b2); end
         n_cmp++; if (link_data !== exp_link) begin n_fail++; $display("FAIL rand_link cyc %0d got %h want %h", c, link_data, exp_link); end
      end
   endtask

   initial begin
      for (int i = 0; i < NR; i++) begin
         m_regs[i] = '0;
         m_busy[i] = 1'b0;
      end
      test_reset;
      test_dual_write;
      test_bypass;
      test_scoreboard;
      test_link_zero;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the pipeline's 16x16 register file: configurable width and depth, two fully independent write ports, registered reads with write-through bypass, and a per-register busy scoreboard for hazard detection.
- Sits between decode (reads, reservations) and writeback (writes, busy clear). Exports a dedicated link-register tap for branch/return logic.

Parameters:
- DATA_W, 16, register width in bits
- NUM_REGS, 16, number of registers; power of two, 4 to 64
- ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)
- LINK_REG, NUM_REGS-1, index exported on link_data
- ZERO_REG, 0, when 1, register 0 reads 0, ignores writes, never becomes busy
- BYPASS, 1, when 1, reads of a register written in the same cycle return the new data

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-low reset
- rd_addr1  in  ADDR_W  read port 1 address
- rd_addr2  in  ADDR_W  read port 2 address
- rd_data1  out  DATA_W  read port 1 data, registered
- rd_data2  out  DATA_W  read port 2 data, registered
- busy1  out  1  scoreboard bit for rd_addr1, registered with rd_data1
- busy2  out  1  scoreboard bit for rd_addr2, registered with rd_data2
- wr_en1, wr_addr1 (ADDR_W), wr_data1 (DATA_W)  in  write port 1
- wr_en2, wr_addr2 (ADDR_W), wr_data2 (DATA_W)  in  write port 2, independent of port 1
- rsv_en  in  1  reserve (mark busy) register rsv_addr
- rsv_addr  in  ADDR_W  register to reserve
- link_data  out  DATA_W  registered copy of register LINK_REG

Behaviour:
- Reset (rst low at posedge):
  - All registers clear to 0; all busy bits clear.
  - rd_data1, rd_data2 and link_data go to 0; busy1 and busy2 go to 0.
  - Reset overrides any same-cycle write or reservation.
- Writes:
  - On posedge, with rst high, each enabled port writes its register.
  - Both ports enabled to the same address: port 2 data wins.
  - ZERO_REG=1: writes to address 0 are discarded.
- Scoreboard:
  - A write on either port clears the busy bit of its address.
  - rsv_en sets the busy bit of rsv_addr.
  - Reserve and write to the same address in the same cycle: reserve wins, so the bit ends set (a new producer has issued).
  - ZERO_REG=1: reserving address 0 has no effect.
  - Reserving an already busy register keeps it busy; there is no counting.
- Reads:
  - Latency 1. At posedge, rd_dataN captures reg[rd_addrN] and busyN captures busy[rd_addrN].
  - BYPASS=1: the data value is the post-write value, meaning same-cycle write data is forwarded with port 2 taking priority. busyN is the post-update bit, including that cycle's clears and reserves.
  - BYPASS=0: both data and busy are the pre-update values.
  - Both read ports may address the same register; there are no read conflicts.
- link_data: captures reg[LINK_REG] every posedge, following the same bypass rule as the read ports.
- Out-of-range addresses cannot occur, because NUM_REGS is a power of two.
- Reset mid-operation: in-flight reservations are lost and registers are zeroed. Upstream must flush the pipeline in step with the reset.

Decomposition:
- Shared package holds:
  - a DATA_W-sized word typedef;
  - the default NUM_REGS and LINK_REG constants, so decode and writeback agree;
  - a register-address typedef.
- One natural sub-module, regfile_sb_fwd: a combinational next-value mux covering the two write ports, priority and the ZERO_REG mask. It is instantiated three times, for rd1, rd2 and link.
- Storage and the scoreboard stay in the top module.

Test Plan:
- Reset then read: hold rst low, then release it and read r3 and r15. Expect rd_data1=0x0000, link_data=0x0000, busy1=0.
- Dual write and collision: write port1 r4=0x1234 and port2 r5=0xABCD, then read both next cycle and expect 0x1234 and 0xABCD. Then write both ports to r6 (0x1111 and 0x2222) and expect r6=0x2222.
- Bypass: in one cycle write r2=0x00F0 and read r2. Expect rd_data1=0x00F0 after that edge when BYPASS=1, or the old value 0x0000 when BYPASS=0.
- Scoreboard lifecycle:
  - reserve r7 and read r7 next cycle: expect busy1=1;
  - write r7=0x0F0F: expect busy1=0 and rd_data1=0x0F0F;
  - reserve and write r7 in the same cycle: expect busy1=1.
- Link and zero register:
  - write r15=0xBEEF: expect link_data=0xBEEF one cycle later;
  - with ZERO_REG=1, write r0=0xFFFF and reserve r0: expect rd_data=0x0000 and busy=0.
- Reset mid-operation: reserve r3 and write r8=0x5555, then assert rst for one cycle. Expect busy for r3 = 0 and r8 = 0x0000 afterwards.
